// File: rtl/apb_req_bridge.sv
// apb_req_bridge: host valid/ready requests -> small FIFO -> APB master.
// Each request runs SETUP then ACCESS, and one response is returned per request, in order.
// Optional feature macro: APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC cycles
// and flags it with rsp_err. In the default build rsp_err is tied low.
module apb_req_bridge #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_req_bridge: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("apb_req_bridge: TIMEOUT_CYC must fit the 8-bit ACCESS counter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  // Request FIFO storage and pointers
  logic [ADDR_W-1:0] mem_addr_q  [FIFO_DEPTH];
  logic              mem_we_q    [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_wdata_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_full, fifo_empty, push, pop;

  // APB / response registers
  state_e            state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q, psel_q, penable_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  logic [7:0]        tmo_cnt_q;
  logic              rsp_err_q;
`endif

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = !fifo_full && !rst;
  assign push       = req_valid && req_ready;
  // A pop is the FSM starting a new transfer: from IDLE, or straight out of RESP
  // on the handshake cycle.
  assign pop        = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

  // Occupancy next-state: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload write (no reset needed, validity is tracked by count_q)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]  <= req_addr;
      mem_we_q[wr_ptr_q]    <= req_we;
      mem_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // APB sequencing FSM with registered APB and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q   <= S_SETUP;
            paddr_q   <= mem_addr_q[rd_ptr_q];
            pwrite_q  <= mem_we_q[rd_ptr_q];
            pwdata_q  <= mem_wdata_q[rd_ptr_q];
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (pready) begin
            state_q     <= S_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            state_q     <= S_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              state_q   <= S_SETUP;
              paddr_q   <= mem_addr_q[rd_ptr_q];
              pwrite_q  <= mem_we_q[rd_ptr_q];
              pwdata_q  <= mem_wdata_q[rd_ptr_q];
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
